// File: rtl/hist_stat_grid.sv
// Per-block luma histogram: 2 RGB pixels/cycle, read-modify-write into external dual-port SRAM.
// Optional macro HIST_STAT_SAT_EN: counters saturate instead of wrapping.
module hist_stat_grid #(
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned BIN_BITS = 7,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned BLK_W    = 7,
    parameter int unsigned COORD_W  = 12
) (
    input  logic                      pclk,
    input  logic                      rst_n,
    input  logic                      sof_i,
    input  logic [COORD_W-1:0]        frame_width_i,
    input  logic [COORD_W-1:0]        frame_height_i,
    input  logic [COORD_W-1:0]        block_width_i,
    input  logic [COORD_W-1:0]        block_height_i,
    input  logic [BLK_W-1:0]          block_num_h_i,
    input  logic [BLK_W-1:0]          block_num_v_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [PIX_W-1:0]          pixel_fst_r_i,
    input  logic [PIX_W-1:0]          pixel_fst_g_i,
    input  logic [PIX_W-1:0]          pixel_fst_b_i,
    input  logic [PIX_W-1:0]          pixel_sec_r_i,
    input  logic [PIX_W-1:0]          pixel_sec_g_i,
    input  logic [PIX_W-1:0]          pixel_sec_b_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      mem_ren_o,
    output logic [BLK_W+BIN_BITS-1:0] mem_raddr_o,
    input  logic [CNT_W-1:0]          mem_rdata_i,
    output logic                      mem_wen_o,
    output logic [BLK_W+BIN_BITS-1:0] mem_waddr_o,
    output logic [CNT_W-1:0]          mem_wdata_o,
    input  logic                      host_ren_i,
    input  logic [BLK_W+BIN_BITS-1:0] host_raddr_i,
    output logic [CNT_W-1:0]          host_rdata_o,
    output logic                      host_rvalid_o
);

    localparam int unsigned ADDR_W = BLK_W + BIN_BITS;

    typedef enum logic [2:0] {StIdle, StClear, StRun, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [BLK_W-1:0]    clr_h_q, clr_h_d, clr_v_q, clr_v_d;
    logic                drain_q, drain_d;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d, bx_q, bx_d, by_q, by_d;
    logic [BLK_W-1:0]    blk_h_q, blk_h_d, row_base_q, row_base_d;
    logic                s2_valid_q, s2_valid_d;
    logic [ADDR_W-1:0]   s2_addr_q, s2_addr_d;
    logic                fwd_valid_q, fwd_valid_d;
    logic [ADDR_W-1:0]   fwd_addr_q, fwd_addr_d;
    logic [CNT_W-1:0]    fwd_data_q, fwd_data_d;
    logic                done_q, done_d;
    logic                host_rvalid_q, host_rvalid_d;

    function automatic logic [PIX_W-1:0] max3(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        logic [PIX_W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    logic [PIX_W-1:0]    luma_fst, luma_sec;
    logic [PIX_W:0]      luma_sum;
    logic [BIN_BITS-1:0] bin;
    logic [BLK_W-1:0]    blk_idx;
    logic [ADDR_W-1:0]   pix_addr;
    logic                accept, last_x, last_y;
    logic                pipe_wr, clear_wr, host_acc;
    logic [CNT_W-1:0]    rmw_base, rmw_next;

    assign luma_fst = max3(pixel_fst_r_i, pixel_fst_g_i, pixel_fst_b_i);
    assign luma_sec = max3(pixel_sec_r_i, pixel_sec_g_i, pixel_sec_b_i);
    assign luma_sum = {1'b0, luma_fst} + {1'b0, luma_sec} + (PIX_W + 1)'(1);
    // Rounded average is luma_sum>>1; the bin keeps its top BIN_BITS bits.
    assign bin      = BIN_BITS'(luma_sum >> (PIX_W + 1 - BIN_BITS));
    assign blk_idx  = row_base_q + blk_h_q;
    assign pix_addr = {blk_idx, bin};

    assign ready_o  = (state_q == StRun);
    assign accept   = valid_i & ready_o;
    assign last_x   = (x_q == frame_width_i - COORD_W'(2));
    assign last_y   = (y_q == frame_height_i - COORD_W'(1));

    // Previous write to the same address is not yet visible in mem_rdata_i.
    assign rmw_base = (fwd_valid_q && (fwd_addr_q == s2_addr_q)) ? fwd_data_q : mem_rdata_i;
`ifdef HIST_STAT_SAT_EN
    assign rmw_next = (&rmw_base) ? rmw_base : rmw_base + CNT_W'(1);
`else
    assign rmw_next = rmw_base + CNT_W'(1);
`endif

    assign pipe_wr  = s2_valid_q & ~sof_i;
    assign clear_wr = (state_q == StClear);
    assign host_acc = (state_q == StDone) & host_ren_i & ~sof_i;

    always_comb begin
        mem_wen_o   = pipe_wr | clear_wr;
        mem_waddr_o = '0;
        mem_wdata_o = '0;
        if (clear_wr) begin
            mem_waddr_o = clr_addr_q;
        end else if (pipe_wr) begin
            mem_waddr_o = s2_addr_q;
            mem_wdata_o = rmw_next;
        end
        mem_ren_o   = accept | host_acc;
        mem_raddr_o = '0;
        if (accept) begin
            mem_raddr_o = pix_addr;
        end else if (host_acc) begin
            mem_raddr_o = host_raddr_i;
        end
    end

    assign busy_o        = (state_q == StClear) || (state_q == StRun) || (state_q == StDrain);
    assign done_o        = done_q;
    assign host_rvalid_o = host_rvalid_q;
    assign host_rdata_o  = host_rvalid_q ? mem_rdata_i : '0;

    always_comb begin
        state_d       = state_q;
        clr_addr_d    = clr_addr_q;
        clr_h_d       = clr_h_q;
        clr_v_d       = clr_v_q;
        drain_d       = drain_q;
        x_d           = x_q;
        y_d           = y_q;
        bx_d          = bx_q;
        by_d          = by_q;
        blk_h_d       = blk_h_q;
        row_base_d    = row_base_q;
        done_d        = 1'b0;
        s2_valid_d    = accept & ~sof_i;
        s2_addr_d     = pix_addr;
        fwd_valid_d   = pipe_wr;
        fwd_addr_d    = s2_addr_q;
        fwd_data_d    = rmw_next;
        host_rvalid_d = host_acc;

        if (sof_i) begin
            state_d    = StClear;
            clr_addr_d = '0;
            clr_h_d    = '0;
            clr_v_d    = '0;
            drain_d    = 1'b0;
            x_d        = '0;
            y_d        = '0;
            bx_d       = '0;
            by_d       = '0;
            blk_h_d    = '0;
            row_base_d = '0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StClear: begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                    // Block counters track the sweep so no multiplier is needed for its end.
                    if (&clr_addr_q[BIN_BITS-1:0]) begin
                        if (clr_h_q == block_num_h_i - BLK_W'(1)) begin
                            clr_h_d = '0;
                            if (clr_v_q == block_num_v_i - BLK_W'(1)) begin
                                clr_v_d = '0;
                                state_d = StRun;
                            end else begin
                                clr_v_d = clr_v_q + BLK_W'(1);
                            end
                        end else begin
                            clr_h_d = clr_h_q + BLK_W'(1);
                        end
                    end
                end
                StRun: begin
                    if (accept) begin
                        if (last_x) begin
                            x_d     = '0;
                            bx_d    = '0;
                            blk_h_d = '0;
                            if (last_y) begin
                                y_d        = '0;
                                by_d       = '0;
                                row_base_d = '0;
                                drain_d    = 1'b0;
                                state_d    = StDrain;
                            end else begin
                                y_d = y_q + COORD_W'(1);
                                if (by_q == block_height_i - COORD_W'(1)) begin
                                    by_d       = '0;
                                    row_base_d = row_base_q + block_num_h_i;
                                end else begin
                                    by_d = by_q + COORD_W'(1);
                                end
                            end
                        end else begin
                            x_d = x_q + COORD_W'(2);
                            if (bx_q == block_width_i - COORD_W'(2)) begin
                                bx_d    = '0;
                                blk_h_d = blk_h_q + BLK_W'(1);
                            end else begin
                                bx_d = bx_q + COORD_W'(2);
                            end
                        end
                    end
                end
                StDrain: begin
                    drain_d = 1'b1;
                    if (drain_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            clr_addr_q    <= '0;
            clr_h_q       <= '0;
            clr_v_q       <= '0;
            drain_q       <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            bx_q          <= '0;
            by_q          <= '0;
            blk_h_q       <= '0;
            row_base_q    <= '0;
            s2_valid_q    <= 1'b0;
            s2_addr_q     <= '0;
            fwd_valid_q   <= 1'b0;
            fwd_addr_q    <= '0;
            fwd_data_q    <= '0;
            done_q        <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_addr_q    <= clr_addr_d;
            clr_h_q       <= clr_h_d;
            clr_v_q       <= clr_v_d;
            drain_q       <= drain_d;
            x_q           <= x_d;
            y_q           <= y_d;
            bx_q          <= bx_d;
            by_q          <= by_d;
            blk_h_q       <= blk_h_d;
            row_base_q    <= row_base_d;
            s2_valid_q    <= s2_valid_d;
            s2_addr_q     <= s2_addr_d;
            fwd_valid_q   <= fwd_valid_d;
            fwd_addr_q    <= fwd_addr_d;
            fwd_data_q    <= fwd_data_d;
            done_q        <= done_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

endmodule

// File: tb/tb_hist_stat_grid.sv
// Bench for hist_stat_grid: SRAM model plus write scoreboard; CNT_W=4 to reach overflow quickly.
module tb_hist_stat_grid;

    localparam int PIX_W    = 8;
    localparam int BIN_BITS = 7;
    localparam int CNT_W    = 4;
    localparam int BLK_W    = 7;
    localparam int COORD_W  = 12;
    localparam int ADDR_W   = BLK_W + BIN_BITS;

    logic                pclk, rst_n, sof_i, valid_i, ready_o, busy_o, done_o;
    logic [COORD_W-1:0]  frame_width_i, frame_height_i, block_width_i, block_height_i;
    logic [BLK_W-1:0]    block_num_h_i, block_num_v_i;
    logic [PIX_W-1:0]    fr, fg, fb, sr, sg, sb;
    logic                mem_ren_o, mem_wen_o, host_ren_i, host_rvalid_o;
    logic [ADDR_W-1:0]   mem_raddr_o, mem_waddr_o, host_raddr_i;
    logic [CNT_W-1:0]    mem_rdata, mem_wdata_o, host_rdata_o;

    hist_stat_grid #(
        .PIX_W(PIX_W), .BIN_BITS(BIN_BITS), .CNT_W(CNT_W), .BLK_W(BLK_W), .COORD_W(COORD_W)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .sof_i(sof_i),
        .frame_width_i(frame_width_i), .frame_height_i(frame_height_i),
        .block_width_i(block_width_i), .block_height_i(block_height_i),
        .block_num_h_i(block_num_h_i), .block_num_v_i(block_num_v_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .pixel_fst_r_i(fr), .pixel_fst_g_i(fg), .pixel_fst_b_i(fb),
        .pixel_sec_r_i(sr), .pixel_sec_g_i(sg), .pixel_sec_b_i(sb),
        .busy_o(busy_o), .done_o(done_o),
        .mem_ren_o(mem_ren_o), .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata),
        .mem_wen_o(mem_wen_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
        .host_ren_i(host_ren_i), .host_raddr_i(host_raddr_i),
        .host_rdata_o(host_rdata_o), .host_rvalid_o(host_rvalid_o)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Dual-port SRAM: same-cycle read of a written address returns the old word.
    logic [CNT_W-1:0] sram [0:(1<<ADDR_W)-1];
    always @(posedge pclk) begin
        if (mem_ren_o) mem_rdata <= sram[mem_raddr_o];
        if (mem_wen_o) sram[mem_waddr_o] <= mem_wdata_o;
    end

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [CNT_W-1:0]  d;
    } wr_t;

    wr_t              exp_q[$];
    wr_t              mon_e;
    logic [CNT_W-1:0] model [0:(1<<ADDR_W)-1];
    int n_cmp = 0;
    int n_err = 0;
    int cfg_fw, cfg_fh, cfg_bw, cfg_bh, cfg_nh, cfg_nv, cur_x, cur_y;

    always @(negedge pclk) begin
        #2;
        if (mem_wen_o === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: got addr %0d data %0d, expected no write",
                         mem_waddr_o, mem_wdata_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_waddr_o !== mon_e.a || mem_wdata_o !== mon_e.d) begin
                    n_err++;
                    $display("FAIL wr_scoreboard: got addr %0d data %0d, expected addr %0d data %0d",
                             mem_waddr_o, mem_wdata_o, mon_e.a, mon_e.d);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
`ifdef HIST_STAT_SAT_EN
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
`else
        return v + 1'b1;
`endif
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    task automatic step();
        @(negedge pclk);
        #1;
    endtask

    task automatic set_cfg(input int fw, input int fh, input int bw, input int bh,
                           input int nh, input int nv);
        cfg_fw = fw; cfg_fh = fh; cfg_bw = bw; cfg_bh = bh; cfg_nh = nh; cfg_nv = nv;
        cur_x = 0; cur_y = 0;
        frame_width_i  = COORD_W'(fw);
        frame_height_i = COORD_W'(fh);
        block_width_i  = COORD_W'(bw);
        block_height_i = COORD_W'(bh);
        block_num_h_i  = BLK_W'(nh);
        block_num_v_i  = BLK_W'(nv);
    endtask

    task automatic push_clear();
        wr_t e;
        for (int a = 0; a < (cfg_nh * cfg_nv) << BIN_BITS; a++) begin
            model[a] = '0;
            e.a = ADDR_W'(a);
            e.d = '0;
            exp_q.push_back(e);
        end
    endtask

    task automatic start_frame(input string name);
        int w;
        push_clear();
        step(); valid_i = 1'b0; host_ren_i = 1'b0; sof_i = 1'b1;
        step(); sof_i = 1'b0;
        w = 0;
        while (ready_o !== 1'b1 && w < 5000) begin
            step();
            w++;
        end
        n_cmp++;
        if (w >= 5000) begin
            n_err++;
            $display("FAIL %s_clear_timeout: got ready_o %b, expected 1 within 5000 cycles",
                     name, ready_o);
        end
    endtask

    task automatic drive_pair(input int gap, input int r1, input int g1, input int b1,
                              input int r2, input int g2, input int b2);
        int w, bin, blk, a;
        wr_t e;
        for (int i = 0; i < gap; i++) begin
            step(); valid_i = 1'b0;
        end
        step();
        valid_i = 1'b1;
        fr = PIX_W'(r1); fg = PIX_W'(g1); fb = PIX_W'(b1);
        sr = PIX_W'(r2); sg = PIX_W'(g2); sb = PIX_W'(b2);
        w = 0;
        while (ready_o !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        if (w >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL pair_accept_timeout: got ready_o %b, expected 1", ready_o);
            valid_i = 1'b0;
        end else begin
            bin = ((max3(r1, g1, b1) + max3(r2, g2, b2) + 1) / 2) >> (PIX_W - BIN_BITS);
            blk = (cur_y / cfg_bh) * cfg_nh + cur_x / cfg_bw;
            a   = (blk << BIN_BITS) + bin;
            model[a] = inc(model[a]);
            e.a = ADDR_W'(a);
            e.d = model[a];
            exp_q.push_back(e);
            cur_x += 2;
            if (cur_x == cfg_fw) begin
                cur_x = 0;
                cur_y++;
            end
        end
    endtask

    task automatic finish_frame(input string name);
        int first, cnt;
        first = 0;
        cnt   = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) valid_i = 1'b0;
            if (done_o === 1'b1) begin
                cnt++;
                if (first == 0) first = k;
            end
        end
        // Accept edge, two DRAIN cycles, then DONE: pulse seen at the third sample.
        n_cmp++;
        if (first != 3 || cnt != 1) begin
            n_err++;
            $display("FAIL %s_done: got first at %0d count %0d, expected first at 3 count 1",
                     name, first, cnt);
        end
        n_cmp++;
        if (exp_q.size() != 0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d pending writes busy %b, expected 0 pending busy 0",
                     name, exp_q.size(), busy_o);
        end
    endtask

    task automatic host_check(input string name, input int a, input int d);
        step(); valid_i = 1'b0; host_ren_i = 1'b1; host_raddr_i = ADDR_W'(a);
        step(); host_ren_i = 1'b0;
        n_cmp++;
        if (host_rvalid_o !== 1'b1 || host_rdata_o !== CNT_W'(d)) begin
            n_err++;
            $display("FAIL %s: got rvalid %b data %0d at addr %0d, expected rvalid 1 data %0d",
                     name, host_rvalid_o, host_rdata_o, a, d);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sof_i = 1'b0; valid_i = 1'b1; host_ren_i = 1'b0; host_raddr_i = '0;
        fr = '0; fg = '0; fb = '0; sr = '0; sg = '0; sb = '0;
        set_cfg(4, 2, 2, 2, 2, 1);
        repeat (3) step();
        n_cmp++;
        if ({ready_o, busy_o, done_o, mem_ren_o, mem_wen_o, host_rvalid_o} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got rdy/busy/done/ren/wen/rv %b, expected 000000",
                     {ready_o, busy_o, done_o, mem_ren_o, mem_wen_o, host_rvalid_o});
        end
        n_cmp++;
        if ({mem_raddr_o, mem_waddr_o, mem_wdata_o, host_rdata_o} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got raddr %0d waddr %0d wdata %0d hdata %0d, expected 0",
                     mem_raddr_o, mem_waddr_o, mem_wdata_o, host_rdata_o);
        end
        valid_i = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_host_ignored();
        step(); host_ren_i = 1'b1; host_raddr_i = '0;
        step(); host_ren_i = 1'b0;
        n_cmp++;
        if (host_rvalid_o !== 1'b0 || mem_ren_o !== 1'b0) begin
            n_err++;
            $display("FAIL host_idle: got rvalid %b ren %b, expected 0 0", host_rvalid_o, mem_ren_o);
        end
    endtask

    task automatic test_clear();
        int nwr, last_wr, last_a, rdy_at;
        set_cfg(4, 4, 2, 2, 2, 2);
        push_clear();
        step(); sof_i = 1'b1;
        step(); sof_i = 1'b0;
        nwr = 0; last_wr = -10; last_a = -1; rdy_at = -1;
        for (int c = 0; c < 1000; c++) begin
            if (ready_o === 1'b1) begin
                rdy_at = c;
                break;
            end
            if (c == 5) begin
                n_cmp++;
                if (busy_o !== 1'b1) begin
                    n_err++;
                    $display("FAIL clear_busy: got busy %b, expected 1", busy_o);
                end
            end
            if (mem_wen_o === 1'b1) begin
                nwr++;
                last_wr = c;
                last_a  = int'(mem_waddr_o);
            end
            step();
        end
        n_cmp++;
        if (nwr != 512 || last_a != 511) begin
            n_err++;
            $display("FAIL clear_count: got %0d writes last addr %0d, expected 512 last 511",
                     nwr, last_a);
        end
        n_cmp++;
        if (rdy_at != last_wr + 1) begin
            n_err++;
            $display("FAIL clear_ready: got ready at %0d, expected %0d", rdy_at, last_wr + 1);
        end
    endtask

    task automatic test_grid();
        set_cfg(4, 2, 2, 2, 2, 1);
        start_frame("grid");
        for (int p = 0; p < 4; p++) drive_pair(0, 10, 200, 30, 10, 200, 30);
        finish_frame("grid");
        host_check("grid_blk0", 100, 2);
        host_check("grid_blk1", 228, 2);
    endtask

    task automatic test_hazard();
        set_cfg(16, 1, 16, 1, 1, 1);
        start_frame("hazard");
        for (int p = 0; p < 8; p++) drive_pair(0, 50, 60, 70, 70, 60, 50);
        finish_frame("hazard");
        host_check("hazard_cnt", 35, 8);
    endtask

    task automatic test_rounding();
        set_cfg(4, 1, 4, 1, 1, 1);
        start_frame("round");
        drive_pair(0, 100, 0, 0, 0, 101, 0);
        drive_pair(0, 255, 255, 255, 255, 255, 255);
        finish_frame("round");
        host_check("round_bin50", 50, 1);
        host_check("round_bin127", 127, 1);
        host_check("round_bin49", 49, 0);
    endtask

    task automatic test_overflow();
        set_cfg(40, 1, 40, 1, 1, 1);
        start_frame("ovf");
        for (int p = 0; p < 20; p++) drive_pair(0, 0, 0, 128, 128, 0, 0);
        finish_frame("ovf");
`ifdef HIST_STAT_SAT_EN
        host_check("ovf_sat", 64, 15);
`else
        host_check("ovf_wrap", 64, 4);
`endif
    endtask

    task automatic test_random();
        set_cfg(8, 4, 4, 2, 2, 2);
        start_frame("rand");
        for (int p = 0; p < 16; p++) begin
            drive_pair(int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)) * 80, int'($urandom_range(0, 255)), 0,
                       int'($urandom_range(0, 3)) * 80, 0, int'($urandom_range(0, 1)) * 40);
        end
        finish_frame("rand");
    endtask

    task automatic test_abort();
        set_cfg(8, 2, 4, 2, 2, 1);
        start_frame("abort");
        for (int p = 0; p < 3; p++) drive_pair(0, 10, 200, 30, 10, 200, 30);
        // This pair is in the write stage when sof_i arrives, so it must never be written.
        step();
        valid_i = 1'b1;
        fr = 8'd255; fg = 8'd255; fb = 8'd255; sr = 8'd255; sg = 8'd255; sb = 8'd255;
        cur_x = 0; cur_y = 0;
        start_frame("abort_restart");
        for (int p = 0; p < 8; p++) drive_pair(0, 10, 200, 30, 10, 200, 30);
        finish_frame("abort_frame");
        host_check("abort_blk0", 100, 4);
        host_check("abort_blk1", 228, 4);
        host_check("abort_bin127", 127, 0);
    endtask

    initial begin
        test_reset();
        test_host_ignored();
        test_clear();
        test_grid();
        test_hazard();
        test_rounding();
        test_overflow();
        test_random();
        test_abort();
        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
